// File: rtl/stack_unit.sv
// Operand stack for the multi-cycle stack CPU: one push/pop/tos command per cycle,
// registered top-of-stack output, occupancy status and sticky misuse flags.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             cmd_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] dout_reg,  dout_next;
    logic             overflow_reg,  overflow_next;
    logic             underflow_reg, underflow_next;
    logic             cmd_err_reg,   cmd_err_next;

    logic             only_push, only_pop, only_tos, multi_cmd;
    logic             do_push, do_pop, do_read;
    logic             set_ovf, set_udf;
    logic [AW-1:0]    wr_idx, top_idx;
    logic [WIDTH-1:0] top_data;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    // Exactly one command is legal; any overlap is rejected wholesale.
    assign multi_cmd = (push & pop) | (push & tos) | (pop & tos);
    assign only_push = push & ~pop  & ~tos;
    assign only_pop  = pop  & ~push & ~tos;
    assign only_tos  = tos  & ~push & ~pop;

    assign do_push = only_push & ~full;
    assign do_pop  = only_pop  & ~empty;
    assign do_read = (only_pop | only_tos) & ~empty;
    assign set_ovf = only_push & full;
    assign set_udf = (only_pop | only_tos) & empty;

    // Write index is count, top is count-1; neither is used at the saturated end.
    assign wr_idx   = AW'(count_reg);
    assign top_idx  = AW'(count_reg - CW'(1));
    assign top_data = mem[top_idx];

    always_comb begin
        count_next = count_reg;
        dout_next  = dout_reg;
        if (do_push) begin
            count_next = count_reg + CW'(1);
        end
        if (do_pop) begin
            count_next = count_reg - CW'(1);
        end
        if (do_read) begin
            dout_next = top_data;
        end
    end

    // A flag raised in the same cycle as clr_err survives the clear.
    always_comb begin
        overflow_next  = set_ovf   | (overflow_reg  & ~clr_err);
        underflow_next = set_udf   | (underflow_reg & ~clr_err);
        cmd_err_next   = multi_cmd | (cmd_err_reg   & ~clr_err);
    end

    // Storage is never reset so it maps onto plain RAM; reset still blocks writes.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg     <= '0;
            dout_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
        end else begin
            count_reg     <= count_next;
            dout_reg      <= dout_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            cmd_err_reg   <= cmd_err_next;
        end
    end

    assign count     = count_reg;
    assign dout      = dout_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_stack_unit.sv
// Table-driven bench for stack_unit: each vector's expected state is queued when
// driven and compared one edge later.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0, pop = 1'b0, tos = 1'b0, clr_err = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty, full, overflow, underflow, cmd_err;

    int tests  = 0;
    int failed = 0;
    int txn    = 0;

    typedef struct {
        logic             rst, push, pop, tos, clr;
        logic [WIDTH-1:0] din;
        logic [CW-1:0]    cnt;
        logic [WIDTH-1:0] dout;
        logic             ov, un, ce;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
        .clr_err(clr_err), .dout(dout), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, input logic pu, input logic po,
                               input logic t, input logic c, input logic [WIDTH-1:0] d,
                               input logic [CW-1:0] n, input logic [WIDTH-1:0] q,
                               input logic ov, input logic un, input logic ce);
        vec_t x;
        x.rst = r; x.push = pu; x.pop = po; x.tos = t; x.clr = c; x.din = d;
        x.cnt = n; x.dout = q; x.ov = ov; x.un = un; x.ce = ce;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL txn %0d %s: got 0x%0h, expected 0x%0h", txn, name, act, exp);
        end
    endtask

    // Drive one cycle's command, queue its expectation, then compare after the edge.
    task automatic step(input vec_t x);
        vec_t e;
        @(negedge clk);
        rst = x.rst; push = x.push; pop = x.pop; tos = x.tos; clr_err = x.clr; din = x.din;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++; failed++;
            $display("[TB] FAIL txn %0d scoreboard: got empty queue, expected entry", txn);
        end else begin
            e = exp_q.pop_front();
            check("count",     32'(count),     32'(e.cnt));
            check("dout",      32'(dout),      32'(e.dout));
            check("empty",     32'(empty),     32'(e.cnt == 0));
            check("full",      32'(full),      32'(e.cnt == CW'(DEPTH)));
            check("overflow",  32'(overflow),  32'(e.ov));
            check("underflow", 32'(underflow), 32'(e.un));
            check("cmd_err",   32'(cmd_err),   32'(e.ce));
            $display("[TB] txn %0d rst=%b push=%b pop=%b tos=%b clr=%b din=%02h -> count=%0d dout=%02h e=%b f=%b ov=%b un=%b ce=%b",
                     txn, e.rst, e.push, e.pop, e.tos, e.clr, e.din,
                     count, dout, empty, full, overflow, underflow, cmd_err);
        end
        txn++;
    endtask

    initial begin
        //                 rst pu po t  clr din    cnt dout   ov un ce
        tbl.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0)); // reset
        tbl.push_back(v(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0)); // idle
        tbl.push_back(v(1, 1, 0, 0, 0, 8'h11, 1, 8'h00, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 8'h22, 2, 8'h00, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 8'h33, 3, 8'h00, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 8'h00, 3, 8'h33, 0, 0, 0)); // tos
        tbl.push_back(v(1, 0, 1, 0, 0, 8'h00, 2, 8'h33, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 8'h00, 1, 8'h22, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 8'h00, 0, 8'h11, 0, 0, 0));
        for (int i = 1; i <= DEPTH; i++)                              // fill 01..08
            tbl.push_back(v(1, 1, 0, 0, 0, 8'(i), CW'(i), 8'h11, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 8'hFF, 8, 8'h11, 1, 0, 0)); // push while full
        tbl.push_back(v(1, 0, 1, 0, 0, 8'h00, 7, 8'h08, 1, 0, 0)); // 0xFF never written
        tbl.push_back(v(1, 0, 0, 0, 1, 8'h00, 7, 8'h08, 0, 0, 0)); // clear overflow
        for (int i = 7; i >= 1; i--)                                  // drain 07..01
            tbl.push_back(v(1, 0, 1, 0, 0, 8'h00, CW'(i-1), 8'(i), 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 8'h00, 0, 8'h01, 0, 1, 0)); // pop empty
        tbl.push_back(v(1, 0, 0, 1, 0, 8'h00, 0, 8'h01, 0, 1, 0)); // tos empty
        tbl.push_back(v(1, 0, 0, 0, 1, 8'h00, 0, 8'h01, 0, 0, 0)); // clear
        tbl.push_back(v(1, 0, 1, 0, 1, 8'h00, 0, 8'h01, 0, 1, 0)); // set beats clear
        tbl.push_back(v(1, 0, 0, 0, 1, 8'h00, 0, 8'h01, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 8'h44, 1, 8'h01, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 8'h55, 2, 8'h01, 0, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 0, 8'h99, 2, 8'h01, 0, 0, 1)); // push+pop
        tbl.push_back(v(1, 0, 0, 1, 0, 8'h00, 2, 8'h55, 0, 0, 1)); // top intact
        tbl.push_back(v(1, 0, 1, 1, 0, 8'h00, 2, 8'h55, 0, 0, 1)); // pop+tos
        tbl.push_back(v(1, 1, 1, 1, 1, 8'h77, 2, 8'h55, 0, 0, 1)); // set beats clear
        tbl.push_back(v(1, 0, 0, 0, 1, 8'h00, 2, 8'h55, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 8'hAA, 3, 8'h55, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 0, 8'h66, 3, 8'h55, 0, 0, 1)); // push+tos
        tbl.push_back(v(1, 1, 0, 0, 0, 8'hBB, 4, 8'h55, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0)); // reset beats pop
        tbl.push_back(v(1, 1, 0, 0, 0, 8'h5C, 1, 8'h00, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 8'h00, 1, 8'h5C, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset between two pops, then push/pop back-to-back with no idle gap.
        step(v(1, 1, 0, 0, 0, 8'h5D, 2, 8'h5C, 0, 0, 0));
        step(v(1, 0, 1, 0, 0, 8'h00, 1, 8'h5D, 0, 0, 0));
        step(v(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        step(v(1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0));
        step(v(1, 1, 0, 0, 1, 8'hC3, 1, 8'h00, 0, 0, 0));
        step(v(1, 0, 1, 0, 0, 8'h00, 0, 8'hC3, 0, 0, 0));

        if (exp_q.size() != 0) begin
            tests++; failed++;
            $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware operand stack that executes the push, pop and top-of-stack commands issued each cycle by the multi-cycle stack CPU controller.
- Stores pushed words and returns the top word on a registered output.
- Reports full/empty status and latches sticky error flags for misuse: overflow, underflow, and illegal command combinations.
- Sits between the controller/datapath and the A/B operand registers. A and B are loaded from dout one cycle after a pop or tos.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of stack entries; must be ≥2.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-low.
- push  input  1  write din onto stack this cycle.
- pop  input  1  remove top entry and present it on dout.
- tos  input  1  present top entry on dout without removing it.
- din  input  WIDTH  push data (memory read data or ALU result, selected upstream).
- clr_err  input  1  synchronous clear of overflow, underflow and cmd_err.
- dout  output  WIDTH  registered top-of-stack read data.
- count  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  count==0 (combinational from count).
- full  output  1  count==DEPTH (combinational from count).
- overflow  output  1  sticky; push attempted while full.
- underflow  output  1  sticky; pop or tos attempted while empty.
- cmd_err  output  1  sticky; more than one of push/pop/tos asserted in one cycle.

Behaviour:
- All state updates on posedge clk. When rst==0 at an edge:
  - count=0, dout=0, overflow=0, underflow=0, cmd_err=0.
  - Storage array contents are not cleared.
  - Reset overrides every command in that cycle, including mid-sequence (e.g. between pop and a following pop).
- Storage: DEPTH×WIDTH register array; write index = count, top index = count-1.
- Command decode per cycle (exactly one command is legal):
  - Idle (none asserted): no change; dout holds its value.
  - push, not full: mem[count] <= din; count <= count+1; dout unchanged.
  - push, full: array and count unchanged; overflow <= 1.
  - pop, not empty: dout <= mem[count-1]; count <= count-1.
  - pop, empty: dout and count unchanged; underflow <= 1.
  - tos, not empty: dout <= mem[count-1]; count unchanged.
  - tos, empty: dout unchanged; underflow <= 1.
  - Two or more of push/pop/tos: no change to array, count or dout; cmd_err <= 1.
- Latency: dout is valid on the edge following pop/tos. It is readable the next cycle, which is the cycle the controller asserts lda or ldb. It holds until the next successful pop/tos or reset.
- Push then immediate tos or pop in the next cycle returns the just-pushed value; no bypass is needed because the write completes at the first edge.
- clr_err==1: all three sticky flags <= 0, except a flag set by an error in that same cycle, which stays 1 (set wins over clear). clr_err does not affect count or dout.
- No wrap-around: count saturates at 0 and DEPTH; indices never alias.
- empty and full derive only from count; no separate state is kept.
- X-free: no output is derived from uninitialised array entries except dout after a pop/tos into an entry never written. This cannot occur while count tracks correctly.

Test Plan:
- Reset then idle: rst=0 for 1 cycle, then rst=1 -> count=0, empty=1, full=0, dout=0, all flags 0.
- Push 0x11, 0x22, 0x33; tos; pop; pop -> after tos dout=0x33, count=3. After first pop dout=0x33, count=2. After second pop dout=0x22, count=1.
- Fill to DEPTH=8 with 0x01..0x08 -> full=1, count=8. Push 0xFF -> count stays 8, overflow=1. Pop -> dout=0x08, which proves 0xFF was not written.
- From empty, pop then tos -> underflow=1, count=0, dout unchanged. Assert clr_err -> underflow=0 next cycle. Pop while clr_err=1 -> underflow remains 1.
- push=1 and pop=1 together with count=2 -> cmd_err=1, count=2, dout unchanged, top entry unchanged (verify by tos).
- Push 0xAA, 0xBB; assert rst=0 in the cycle a pop is issued -> count=0, dout=0, flags 0. Push 0x5C then tos -> dout=0x5C.
